// File: rtl/gesture_pkg.sv
// Shared constants, FSM state encoding and helpers for the gesture sampler and recognizer.
package gesture_pkg;

    localparam int N_SAMPLES_DEF   = 30;
    localparam int ACC_SCALE_MUL   = 981;
    localparam int ACC_SCALE_SHIFT = 14;
    localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        WAIT_RES = 3'd2,
        OUTPUT   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    // Magnitude of a signed difference; the unrepresentable -2^31 saturates to all-ones.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x);
        logic [31:0] r;
        if (x == 32'sh8000_0000) begin
            r = 32'hFFFF_FFFF;
        end else if (x < 32'sd0) begin
            r = 32'(-x);
        end else begin
            r = 32'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/gesture_accel_scaler.sv
// Raw MPU axis sample (16384 LSB/g) to signed m/s^2 x100; floors toward -inf.
module accel_scaler
    import gesture_pkg::*;
(
    input  logic signed [15:0] raw_accel,
    output logic signed [31:0] scaled
);

    logic signed [31:0] product_s;

    // Multiply in 32 bits (|raw| * 981 < 2^31) then arithmetic shift down.
    always_comb begin
        product_s = 32'(raw_accel) * ACC_SCALE_MUL;
        scaled    = product_s >>> ACC_SCALE_SHIFT;
    end

endmodule

// File: rtl/gesture_sampler.sv
// Movement-triggered sample framer feeding the gesture recognizer.
// Optional static-letter emission is enabled with `define GS_STATIC_EMIT_EN.
module gesture_sampler
    import gesture_pkg::*;
#(
    parameter int N_SAMPLES       = N_SAMPLES_DEF,
    parameter int DECIM           = 4,
    parameter int START_THRESH    = 200,
    parameter int GAP_CYCLES      = 1000000,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int COOLDOWN_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] raw_accel,
    input  logic               raw_valid,
    input  logic [7:0]         letra_in,
    output logic               mov,
    output logic signed [31:0] mpu_valor,
    output logic               mpu_valid,
    output logic [7:0]         letra_base,
    input  logic               rec_ready,
    input  logic [7:0]         rec_letra,
    output logic [7:0]         out_char,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int SC_W = $clog2(N_SAMPLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [31:0] THRESH_U = 32'(START_THRESH);

    state_t             state_r;
    logic signed [31:0] scaled_s;
    logic signed [31:0] diff_s;
    logic               trigger_s;
    logic signed [31:0] prev_scaled_r;
    logic               prev_ok_r;
    logic [7:0]         decim_cnt_r;
    logic [SC_W-1:0]    sample_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [TO_W-1:0]    wait_cnt_r;
    logic [CD_W-1:0]    cool_cnt_r;
`ifdef GS_STATIC_EMIT_EN
    logic [7:0]         hold_cnt_r;
    logic               hold_act_r;
    logic [7:0]         letra_prev_r;
`endif

    accel_scaler u_scaler (
        .raw_accel (raw_accel),
        .scaled    (scaled_s)
    );

    // Movement trigger: large step between consecutive raw samples.
    always_comb begin
        diff_s    = scaled_s - prev_scaled_r;
        trigger_s = prev_ok_r && raw_valid && (abs_sat(diff_s) >= THRESH_U);
    end

    // Main FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            mov           <= 1'b0;
            mpu_valid     <= 1'b0;
            mpu_valor     <= 32'sd0;
            letra_base    <= CHAR_UNKNOWN;
            out_char      <= CHAR_UNKNOWN;
            out_valid     <= 1'b0;
            prev_scaled_r <= 32'sd0;
            prev_ok_r     <= 1'b0;
            decim_cnt_r   <= 8'd0;
            sample_cnt_r  <= '0;
            gap_cnt_r     <= '0;
            wait_cnt_r    <= '0;
            cool_cnt_r    <= '0;
`ifdef GS_STATIC_EMIT_EN
            hold_cnt_r    <= 8'd0;
            hold_act_r    <= 1'b0;
            letra_prev_r  <= CHAR_UNKNOWN;
`endif
        end else begin
            mpu_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    letra_base <= letra_in;
                    if (raw_valid) begin
                        prev_scaled_r <= scaled_s;
                        prev_ok_r     <= 1'b1;
                    end
                    if (trigger_s) begin
                        // Trigger sample goes out as sample 0 together with mov.
                        state_r      <= CAPTURE;
                        mov          <= 1'b1;
                        mpu_valid    <= 1'b1;
                        mpu_valor    <= scaled_s;
                        decim_cnt_r  <= 8'd0;
                        sample_cnt_r <= SC_W'(1);
                        gap_cnt_r    <= '0;
                    end
`ifdef GS_STATIC_EMIT_EN
                    letra_prev_r <= letra_in;
                    if (trigger_s) begin
                        hold_act_r <= 1'b0;
                    end else if (letra_in != letra_prev_r) begin
                        hold_cnt_r <= 8'd0;
                        hold_act_r <= 1'b1;
                    end else if (hold_act_r && raw_valid) begin
                        if (hold_cnt_r == 8'd254) begin
                            out_char   <= letra_in;
                            out_valid  <= 1'b1;
                            hold_act_r <= 1'b0;
                            state_r    <= OUTPUT;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
`endif
                end
                CAPTURE: begin
                    if (sample_cnt_r == SC_W'(N_SAMPLES)) begin
                        state_r    <= WAIT_RES;
                        wait_cnt_r <= '0;
                    end else if (raw_valid) begin
                        gap_cnt_r <= '0;
                        if (decim_cnt_r == 8'(DECIM - 1)) begin
                            decim_cnt_r  <= 8'd0;
                            mpu_valid    <= 1'b1;
                            mpu_valor    <= scaled_s;
                            sample_cnt_r <= sample_cnt_r + SC_W'(1);
                        end else begin
                            decim_cnt_r <= decim_cnt_r + 8'd1;
                        end
                    end else if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        // Sensor stream stalled: abandon the frame silently.
                        state_r    <= COOLDOWN;
                        mov        <= 1'b0;
                        cool_cnt_r <= '0;
                        prev_ok_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                WAIT_RES: begin
                    if (rec_ready) begin
                        out_char  <= rec_letra;
                        out_valid <= 1'b1;
                        state_r   <= OUTPUT;
                    end else if (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        out_char  <= CHAR_UNKNOWN;
                        out_valid <= 1'b1;
                        state_r   <= OUTPUT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TO_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        mov        <= 1'b0;
                        cool_cnt_r <= '0;
                        prev_ok_r  <= 1'b0;
                        state_r    <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // mov low long enough for the recognizer to rewind its buffer.
                    if (cool_cnt_r == CD_W'(COOLDOWN_CYCLES - 1)) begin
                        state_r <= IDLE;
                    end else begin
                        cool_cnt_r <= cool_cnt_r + CD_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mov       <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_sampler.sv
// Directed self-checking bench for gesture_sampler and accel_scaler.
`timescale 1ns/1ps
module tb_gesture_sampler;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] raw_accel;
    logic               raw_valid;
    logic [7:0]         letra_in;
    logic               mov;
    logic signed [31:0] mpu_valor;
    logic               mpu_valid;
    logic [7:0]         letra_base;
    logic               rec_ready;
    logic [7:0]         rec_letra;
    logic [7:0]         out_char;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] sc_in;
    logic signed [31:0] sc_out;

    int n_checks = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    int base_cnt = 0;

    always #5 clk = ~clk;

    gesture_sampler #(.GAP_CYCLES(200)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_accel  (raw_accel),
        .raw_valid  (raw_valid),
        .letra_in   (letra_in),
        .mov        (mov),
        .mpu_valor  (mpu_valor),
        .mpu_valid  (mpu_valid),
        .letra_base (letra_base),
        .rec_ready  (rec_ready),
        .rec_letra  (rec_letra),
        .out_char   (out_char),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    accel_scaler u_sc (
        .raw_accel (sc_in),
        .scaled    (sc_out)
    );

    always @(negedge clk) begin
        if (mpu_valid === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic signed [15:0] v);
        raw_accel = v;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_groups(input int n);
        logic signed [15:0] v;
        logic signed [31:0] e;
        for (int g = 0; g < n; g++) begin
            case (g % 3)
                0: begin v = 16'sd16384;  e = 32'sd981;  end
                1: begin v = -16'sd16384; e = -32'sd981; end
                default: begin v = -16'sd1; e = -32'sd1; end
            endcase
            for (int j = 0; j < 4; j++) begin
                strobe((j == 3) ? v : 16'sd100);
                chk("frame_valid", 32'(mpu_valid), (j == 3) ? 32'd1 : 32'd0);
                if (j == 3) chk("frame_valor", mpu_valor, e);
            end
            chk("frame_mov", 32'(mov), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1; raw_accel = 16'sd0; raw_valid = 1'b0; letra_in = 8'h41;
        rec_ready = 1'b0; rec_letra = 8'h00; out_ready = 1'b0; sc_in = 16'sd0;
        #12;
        chk("rst_mov", 32'(mov), 32'd0);
        chk("rst_mpu_valid", 32'(mpu_valid), 32'd0);
        chk("rst_mpu_valor", mpu_valor, 32'd0);
        chk("rst_letra_base", 32'(letra_base), 32'h3F);
        chk("rst_out_char", 32'(out_char), 32'h3F);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        sc_in = 16'sd16384;  #1; chk("scale_pos1g", sc_out, 32'sd981);
        sc_in = -16'sd16384; #1; chk("scale_neg1g", sc_out, -32'sd981);
        sc_in = -16'sd1;     #1; chk("scale_neg1", sc_out, -32'sd1);
        sc_in = 16'sd0;      #1; chk("scale_zero", sc_out, 32'sd0);

        // Frame 1: trigger on 0,0,4096, then result "Z" with back-pressure.
        letra_in = 8'h44;
        tick();
        chk("idle_letra_follow", 32'(letra_base), 32'h44);
        strobe(16'sd0);    chk("no_trig_first", 32'(mov), 32'd0);
        strobe(16'sd0);    chk("no_trig_flat", 32'(mov), 32'd0);
        strobe(16'sd4096);
        chk("trig_mov", 32'(mov), 32'd1);
        chk("trig_valid", 32'(mpu_valid), 32'd1);
        chk("trig_valor", mpu_valor, 32'sd245);
        chk("trig_letra", 32'(letra_base), 32'h44);
        letra_in = 8'h58;
        send_groups(29);
        tick();
        chk("frame1_pulses", 32'(pulse_cnt), 32'd30);
        chk("wait_mov", 32'(mov), 32'd1);
        for (int i = 0; i < 8; i++) strobe(16'sd16384);
        tick();
        chk("wait_no_extra", 32'(pulse_cnt), 32'd30);
        chk("letra_frozen", 32'(letra_base), 32'h44);
        rec_letra = 8'h5A; rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        chk("res_valid", 32'(out_valid), 32'd1);
        chk("res_char", 32'(out_char), 32'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_mov", 32'(mov), 32'd1);
            chk("hold_char", 32'(out_char), 32'h5A);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_valid", 32'(out_valid), 32'd0);
        chk("accept_mov", 32'(mov), 32'd0);
        letra_in = 8'h51;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("cool_mov", 32'(mov), 32'd0);
            chk("cool_letra", 32'(letra_base), 32'h44);
        end
        tick();
        chk("idle_again", 32'(letra_base), 32'h51);

        // Frame 2: prev_ok must be clear after cooldown; negative floor; timeout.
        strobe(16'sd8192);  chk("prev_ok_cleared", 32'(mov), 32'd0);
        strobe(16'sd8192);  chk("no_trig_same", 32'(mov), 32'd0);
        strobe(-16'sd8192);
        chk("trig2_mov", 32'(mov), 32'd1);
        chk("trig2_valor_floor", mpu_valor, -32'sd491);
        chk("trig2_letra", 32'(letra_base), 32'h51);
        send_groups(29);
        tick();
        chk("frame2_pulses", 32'(pulse_cnt), 32'd60);
        for (int i = 0; i < 4095; i++) tick();
        chk("timeout_early", 32'(out_valid), 32'd0);
        tick();
        chk("timeout_valid", 32'(out_valid), 32'd1);
        chk("timeout_char", 32'(out_char), 32'h3F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("timeout_accept", 32'(out_valid), 32'd0);
        for (int i = 0; i < 70; i++) tick();

        // Frame 3: gap abort after 10 samples.
        letra_in = 8'h52;
        strobe(16'sd0);
        base_cnt = pulse_cnt;
        strobe(16'sd4096);
        chk("trig3_mov", 32'(mov), 32'd1);
        chk("trig3_letra", 32'(letra_base), 32'h52);
        send_groups(9);
        for (int i = 0; i < 199; i++) tick();
        chk("gap_hold", 32'(mov), 32'd1);
        tick();
        chk("gap_abort", 32'(mov), 32'd0);
        chk("gap_no_out", 32'(out_valid), 32'd0);
        chk("gap_pulses", 32'(pulse_cnt - base_cnt), 32'd10);
        for (int i = 0; i < 70; i++) tick();
        chk("gap_still_no_out", 32'(out_valid), 32'd0);

        // Frame 4: asynchronous reset mid-capture.
        strobe(16'sd0);
        strobe(16'sd4096);
        chk("trig4_mov", 32'(mov), 32'd1);
        send_groups(2);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_mov", 32'(mov), 32'd0);
        chk("areset_letra", 32'(letra_base), 32'h3F);
        chk("areset_valid", 32'(mpu_valid), 32'd0);
        chk("areset_valor", mpu_valor, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
